// File: rtl/param_step_cpu.sv
// Single-step accumulator CPU: A/B registers, Z/C flags, PC and a writable program memory.
// Optional CALL/RET return stack is compiled in when CPU_CALL_STACK_EN is defined.
module param_step_cpu #(
  parameter int DATA_WIDTH  = 4,
  parameter int PC_WIDTH    = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  progWe,
  input  logic [PC_WIDTH-1:0]   progAddr,
  input  logic [DATA_WIDTH+4:0] progData,
  output logic [DATA_WIDTH-1:0] aReg,
  output logic [DATA_WIDTH-1:0] bReg,
  output logic                  zf,
  output logic                  cf,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  halted,
  output logic                  fault,
  output logic                  retired
);
  localparam int IW    = DATA_WIDTH + 5;
  localparam int DEPTH = 1 << PC_WIDTH;

  localparam logic [4:0] OP_HALT = 5'b00001;
  localparam logic [4:0] OP_LDA  = 5'b00010;
  localparam logic [4:0] OP_LDB  = 5'b00011;
  localparam logic [4:0] OP_JMP  = 5'b00100;
  localparam logic [4:0] OP_JZ   = 5'b00101;
  localparam logic [4:0] OP_JNZ  = 5'b00110;
  localparam logic [4:0] OP_JC   = 5'b00111;
  localparam logic [4:0] OP_JNC  = 5'b01000;
`ifdef CPU_CALL_STACK_EN
  localparam logic [4:0] OP_CALL = 5'b01001;
  localparam logic [4:0] OP_RET  = 5'b01010;
`endif

  logic [IW-1:0]         mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  zf_q, zf_d, cf_q, cf_d;
  logic                  halted_q, halted_d, retired_q, retired_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d, pc_inc, jmp_tgt;
  logic [IW-1:0]         instr;
  logic [4:0]            op;
  logic [DATA_WIDTH-1:0] arg, alu_x, alu_y;
  logic [DATA_WIDTH:0]   alu_w;
  logic                  exec;

  assign instr   = mem_q[pc_q];
  assign op      = instr[IW-1:DATA_WIDTH];
  assign arg     = instr[DATA_WIDTH-1:0];
  assign exec    = step && !halted_q && !reset;
  assign pc_inc  = pc_q + PC_WIDTH'(1);
  assign jmp_tgt = arg[PC_WIDTH-1:0];

`ifdef CPU_CALL_STACK_EN
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  logic [SPW-1:0]      sp_q, sp_d;
  logic [PC_WIDTH-1:0] stk_q [1 << SPW];
  logic                fault_q, fault_d, push;
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  // op[3] swaps operands so the B-destination group computes f(B,A)
  always_comb begin
    alu_x = op[3] ? b_q : a_q;
    alu_y = op[3] ? a_q : b_q;
    alu_w = '0;
    case (op[2:0])
      3'd0:    alu_w = {1'b0, alu_x} + {1'b0, alu_y};
      3'd1:    alu_w = {1'b0, alu_x} - {1'b0, alu_y};
      3'd2:    alu_w = {1'b0, alu_x & alu_y};
      3'd3:    alu_w = {1'b0, alu_x | alu_y};
      3'd4:    alu_w = {1'b0, alu_x ^ alu_y};
      3'd5:    alu_w = {1'b0, alu_x} + (DATA_WIDTH+1)'(1);
      3'd6:    alu_w = {1'b0, alu_x} - (DATA_WIDTH+1)'(1);
      default: alu_w = {1'b0, ~alu_x};
    endcase
  end

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    zf_d      = zf_q;
    cf_d      = cf_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    retired_d = exec;
`ifdef CPU_CALL_STACK_EN
    sp_d    = sp_q;
    fault_d = fault_q;
    push    = 1'b0;
`endif
    if (exec) begin
      pc_d = pc_inc;
      if (op[4]) begin
        if (op[3]) b_d = alu_w[DATA_WIDTH-1:0];
        else       a_d = alu_w[DATA_WIDTH-1:0];
        zf_d = (alu_w[DATA_WIDTH-1:0] == '0);
        cf_d = alu_w[DATA_WIDTH];
      end else begin
        case (op)
          OP_HALT: begin
            halted_d = 1'b1;
            pc_d     = pc_q;
          end
          OP_LDA: a_d = arg;
          OP_LDB: b_d = arg;
          OP_JMP: pc_d = jmp_tgt;
          OP_JZ:  if (zf_q)  pc_d = jmp_tgt;
          OP_JNZ: if (!zf_q) pc_d = jmp_tgt;
          OP_JC:  if (cf_q)  pc_d = jmp_tgt;
          OP_JNC: if (!cf_q) pc_d = jmp_tgt;
`ifdef CPU_CALL_STACK_EN
          OP_CALL: begin
            if (sp_q == SPW'(STACK_DEPTH)) begin
              fault_d  = 1'b1;
              halted_d = 1'b1;
              pc_d     = pc_q;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SPW'(1);
              pc_d = jmp_tgt;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              fault_d  = 1'b1;
              halted_d = 1'b1;
              pc_d     = pc_q;
            end else begin
              sp_d = sp_q - SPW'(1);
              pc_d = stk_q[sp_q - SPW'(1)];
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_q       <= '0;
      b_q       <= '0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      pc_q      <= '0;
      halted_q  <= 1'b0;
      retired_q <= 1'b0;
`ifdef CPU_CALL_STACK_EN
      sp_q      <= '0;
      fault_q   <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      zf_q      <= zf_d;
      cf_q      <= cf_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
`ifdef CPU_CALL_STACK_EN
      sp_q      <= sp_d;
      fault_q   <= fault_d;
`endif
    end
  end

  // Not reset; the execute path reads the pre-edge word (read-before-write)
  always_ff @(posedge clock) begin
    if (progWe) mem_q[progAddr] <= progData;
  end

`ifdef CPU_CALL_STACK_EN
  always_ff @(posedge clock) begin
    if (push) stk_q[sp_q] <= pc_inc;
  end
`endif

  assign aReg    = a_q;
  assign bReg    = b_q;
  assign zf      = zf_q;
  assign cf      = cf_q;
  assign pc      = pc_q;
  assign halted  = halted_q;
  assign retired = retired_q;
endmodule

// File: tb/tb_param_step_cpu.sv
// Directed bench for param_step_cpu: a 4-bit/8-word core with a 2-deep stack
// plus an 8-bit data-width instance for wide-arithmetic checks.
module tb_param_step_cpu;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1, step = 1'b0, progWe = 1'b0;
  logic [2:0] progAddr = '0;
  logic [8:0] progData = '0;
  logic [3:0] aReg, bReg;
  logic       zf, cf, halted, fault, retired;
  logic [2:0] pc;

  logic        step8 = 1'b0, progWe8 = 1'b0;
  logic [12:0] progData8 = '0;
  logic [7:0]  aReg8, bReg8;
  logic        zf8, cf8, halted8, fault8, retired8;
  logic [2:0]  pc8;

  param_step_cpu #(.DATA_WIDTH(4), .PC_WIDTH(3), .STACK_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .step(step), .progWe(progWe), .progAddr(progAddr),
    .progData(progData), .aReg(aReg), .bReg(bReg), .zf(zf), .cf(cf), .pc(pc),
    .halted(halted), .fault(fault), .retired(retired));

  param_step_cpu #(.DATA_WIDTH(8), .PC_WIDTH(3), .STACK_DEPTH(2)) dut8 (
    .clock(clock), .reset(reset), .step(step8), .progWe(progWe8), .progAddr(progAddr),
    .progData(progData8), .aReg(aReg8), .bReg(bReg8), .zf(zf8), .cf(cf8), .pc(pc8),
    .halted(halted8), .fault(fault8), .retired(retired8));

`ifdef CPU_CALL_STACK_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  localparam logic [4:0] NOP = 5'd0, HALT = 5'd1, LDA = 5'd2, LDB = 5'd3, JMP = 5'd4;
  localparam logic [4:0] JZ = 5'd5, JNZ = 5'd6, JC = 5'd7, JNC = 5'd8, CALL = 5'd9, RET = 5'd10;
  localparam logic [4:0] ADDA = 5'd16, SUBA = 5'd17, XORA = 5'd20, INCA = 5'd21, NOTA = 5'd23;
  localparam logic [4:0] DECB = 5'd30;

  int n_cmp = 0, n_bad = 0;
  logic [8:0]  prog  [8];
  logic [12:0] prog8 [8];

  function automatic logic [8:0] ins(input logic [4:0] op, input logic [3:0] arg);
    return {op, arg};
  endfunction

  task automatic load_prog();
    step = 1'b0;
    for (int i = 0; i < 8; i++) begin
      progWe = 1'b1; progAddr = 3'(i); progData = prog[i];
      @(posedge clock); #1;
    end
    progWe = 1'b0;
  endtask

  task automatic load_prog8();
    step8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      progWe8 = 1'b1; progAddr = 3'(i); progData8 = prog8[i];
      @(posedge clock); #1;
    end
    progWe8 = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1; @(posedge clock); #1; reset = 1'b0;
  endtask

  task automatic step_once();
    step = 1'b1; @(posedge clock); #1; step = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step = 1'b1;
    @(posedge clock); #1;
    step = 1'b0; reset = 1'b0;
    n_cmp++; if ({aReg, bReg} !== 8'h00) begin n_bad++; $display("FAIL reset_ab: got %h want 00", {aReg, bReg}); end
    n_cmp++; if ({zf, cf} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {zf, cf}); end
    n_cmp++; if (pc !== 3'd0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", pc); end
    n_cmp++; if ({halted, fault, retired} !== 3'b000) begin n_bad++; $display("FAIL reset_status: got %b want 000", {halted, fault, retired}); end
  endtask

  task automatic test_program();
    int ret_cnt = 0;
    prog = '{ins(LDA, 4), ins(LDB, 3), ins(DECB, 0), ins(JC, 6),
             ins(INCA, 0), ins(JMP, 2), ins(HALT, 0), ins(HALT, 0)};
    load_prog();
    pulse_reset();
    step = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock); #1;
      if (retired) ret_cnt++;
      if (halted) break;
    end
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL prog_halted: got %b want 1 (timeout)", halted); end
    n_cmp++; if (pc !== 3'd6) begin n_bad++; $display("FAIL prog_pc: got %0d want 6", pc); end
    n_cmp++; if (aReg !== 4'h7) begin n_bad++; $display("FAIL prog_a: got %h want 7", aReg); end
    n_cmp++; if (bReg !== 4'hF) begin n_bad++; $display("FAIL prog_b: got %h want f", bReg); end
    n_cmp++; if ({zf, cf} !== 2'b01) begin n_bad++; $display("FAIL prog_flags: got %b want 01", {zf, cf}); end
    n_cmp++; if (ret_cnt !== 17) begin n_bad++; $display("FAIL prog_retired: got %0d want 17", ret_cnt); end
  endtask

  task automatic test_freeze();
    step = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      n_cmp++; if (retired !== 1'b0) begin n_bad++; $display("FAIL freeze_retired[%0d]: got %b want 0", c, retired); end
      n_cmp++; if (pc !== 3'd6) begin n_bad++; $display("FAIL freeze_pc[%0d]: got %0d want 6", c, pc); end
    end
    step = 1'b0;
    n_cmp++; if ({aReg, bReg} !== 8'h7F) begin n_bad++; $display("FAIL freeze_ab: got %h want 7f", {aReg, bReg}); end
    pulse_reset();
    n_cmp++; if ({pc, halted} !== 4'b000_0) begin n_bad++; $display("FAIL freeze_reset: got pc=%0d halted=%b want 0/0", pc, halted); end
  endtask

  task automatic test_wrap();
    int ret_cnt = 0;
    for (int i = 0; i < 8; i++) prog[i] = ins(NOP, 0);
    load_prog();
    pulse_reset();
    step = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1;
      if (retired) ret_cnt++;
      n_cmp++; if (pc !== 3'(i + 1)) begin n_bad++; $display("FAIL wrap_pc[%0d]: got %0d want %0d", i, pc, 3'(i + 1)); end
    end
    step = 1'b0;
    @(posedge clock); #1;
    n_cmp++; if (ret_cnt !== 9) begin n_bad++; $display("FAIL wrap_retired: got %0d want 9", ret_cnt); end
    n_cmp++; if (retired !== 1'b0) begin n_bad++; $display("FAIL wrap_idle_retired: got %b want 0", retired); end
  endtask

  task automatic test_rmw();
    prog[0] = ins(LDA, 5);
    for (int i = 1; i < 8; i++) prog[i] = ins(NOP, 0);
    load_prog();
    pulse_reset();
    step = 1'b1; progWe = 1'b1; progAddr = 3'd0; progData = ins(LDA, 9);
    @(posedge clock); #1;
    progWe = 1'b0;
    n_cmp++; if (aReg !== 4'h5) begin n_bad++; $display("FAIL rmw_old: got %h want 5", aReg); end
    repeat (7) begin @(posedge clock); #1; end
    n_cmp++; if (pc !== 3'd0) begin n_bad++; $display("FAIL rmw_revisit_pc: got %0d want 0", pc); end
    @(posedge clock); #1;
    step = 1'b0;
    n_cmp++; if (aReg !== 4'h9) begin n_bad++; $display("FAIL rmw_new: got %h want 9", aReg); end
  endtask

  task automatic test_branches();
    logic [2:0] exp_pc [6] = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd7, 3'd0};
    prog = '{ins(JZ, 5), ins(JNC, 3), ins(HALT, 0), ins(XORA, 0),
             ins(JNZ, 0), ins(JZ, 7), ins(HALT, 0), ins(NOTA, 0)};
    load_prog();
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      step_once();
      n_cmp++; if (pc !== exp_pc[i]) begin n_bad++; $display("FAIL branch_pc[%0d]: got %0d want %0d", i, pc, exp_pc[i]); end
    end
    n_cmp++; if ({aReg, zf, cf} !== 6'b1111_00) begin n_bad++; $display("FAIL branch_not: got a=%h zf=%b cf=%b want f/0/0", aReg, zf, cf); end
  endtask

  task automatic test_dw8();
    prog8 = '{{LDA, 8'hFF}, {LDB, 8'h01}, {ADDA, 8'h00}, {SUBA, 8'h00},
              {HALT, 8'h00}, {HALT, 8'h00}, {HALT, 8'h00}, {HALT, 8'h00}};
    load_prog8();
    pulse_reset();
    step8 = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    n_cmp++; if ({aReg8, zf8, cf8} !== 10'h003) begin n_bad++; $display("FAIL dw8_add: got a=%h zf=%b cf=%b want 00/1/1", aReg8, zf8, cf8); end
    @(posedge clock); #1;
    step8 = 1'b0;
    n_cmp++; if ({aReg8, zf8, cf8} !== 10'h3FD) begin n_bad++; $display("FAIL dw8_sub: got a=%h zf=%b cf=%b want ff/0/1", aReg8, zf8, cf8); end
    n_cmp++; if (bReg8 !== 8'h01) begin n_bad++; $display("FAIL dw8_b: got %h want 01", bReg8); end
  endtask

  task automatic test_stack();
    prog = '{ins(CALL, 1), ins(CALL, 2), ins(CALL, 3), ins(HALT, 0),
             ins(HALT, 0), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0)};
    load_prog();
    pulse_reset();
    repeat (3) step_once();
    n_cmp++; if (pc !== (STK ? 3'd2 : 3'd3)) begin n_bad++; $display("FAIL call_nest_pc: got %0d want %0d", pc, STK ? 2 : 3); end
    n_cmp++; if ({fault, halted} !== (STK ? 2'b11 : 2'b00)) begin n_bad++; $display("FAIL call_nest_fault: got %b want %b", {fault, halted}, STK ? 2'b11 : 2'b00); end
    step_once();
    n_cmp++; if ({pc, halted} !== (STK ? 4'b010_1 : 4'b011_1)) begin n_bad++; $display("FAIL call_nest_after: got pc=%0d halted=%b", pc, halted); end

    prog[0] = ins(RET, 0);
    load_prog();
    pulse_reset();
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_reset: got %b want 0", fault); end
    step_once();
    n_cmp++; if ({pc, fault, halted} !== (STK ? 5'b000_11 : 5'b001_00)) begin n_bad++; $display("FAIL ret_underflow: got pc=%0d fault=%b halted=%b", pc, fault, halted); end

    prog = '{ins(CALL, 4), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0),
             ins(RET, 0), ins(HALT, 0), ins(HALT, 0), ins(HALT, 0)};
    load_prog();
    pulse_reset();
    step_once();
    n_cmp++; if (pc !== (STK ? 3'd4 : 3'd1)) begin n_bad++; $display("FAIL call_pc: got %0d want %0d", pc, STK ? 4 : 1); end
    step_once();
    n_cmp++; if ({pc, halted} !== (STK ? 4'b001_0 : 4'b001_1)) begin n_bad++; $display("FAIL ret_pc: got pc=%0d halted=%b", pc, halted); end
    step_once();
    n_cmp++; if ({pc, halted, fault} !== 5'b001_10) begin n_bad++; $display("FAIL callret_end: got pc=%0d halted=%b fault=%b want 1/1/0", pc, halted, fault); end
  endtask

  initial begin
    test_reset();
    test_program();
    test_freeze();
    test_wrap();
    test_rmw();
    test_branches();
    test_dw8();
    test_stack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
